// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA state encoding and CPU-visible register addresses.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nes_pkg;

    // OAM DMA sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    // CPU write here starts sprite DMA; the written byte is the source page.
    localparam logic [15:0] NES_OAMDMA  = 16'h4014;
    // PPU OAM data port; every DMA byte is written here.
    localparam logic [15:0] NES_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma_arbiter.sv
// CPU / sprite-DMA bus arbiter: a CPU write to the DMA register halts the CPU and
// copies XFER_LEN bytes from page {data,8'h00} to the OAM data port as read/write pairs.
// Latency: first DMA read 2 cycles after the trigger write (3 if an align cycle is needed);
// bus outputs are combinational from state, cpu_d_in is bus_d_in unregistered.
// Backpressure: cpu_ready=0 halts the CPU for the whole transfer; CPU writes pending at
// halt time are allowed to finish on the bus before the copy starts.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   cpu_addr/d_out/write  CPU bus request
//   cpu_ready             0 stalls the CPU
//   cpu_d_in              read data returned to the CPU
//   bus_addr/d_out/write  system bus request towards the address decoder
//   bus_d_in              system bus read data
//   dma_active            1 whenever the sequencer is not IDLE
module oam_dma_arbiter
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = NES_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = NES_OAMDATA,
    // Bytes per transfer; power of 2, at most 256 (index is 8 bits wide).
    parameter int unsigned XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    output logic        cpu_ready,
    output logic [7:0]  cpu_d_in,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_d_out,
    output logic        bus_write,
    input  logic [7:0]  bus_d_in,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] idx_q,   idx_d;
    logic [7:0] data_q,  data_d;
    // Free-running even/odd cycle marker; 0 is a "get" (read) cycle. Kept inline
    // because the APU frame logic will later share this same toggle.
    logic       parity_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                // The triggering write still goes out on the bus this cycle.
                if (cpu_write && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_d_out;
                    idx_d   = 8'd0;
                    state_d = HALT;
                end
            end
            HALT: begin
                // Hold off while the CPU is still writing (RMW second write etc.);
                // then start reading on the next even cycle, inserting ALIGN if needed.
                if (!cpu_write) begin
                    state_d = parity_q ? READ : ALIGN;
                end
            end
            ALIGN: begin
                state_d = READ;
            end
            READ: begin
                data_d  = bus_d_in;
                state_d = WRITE;
            end
            WRITE: begin
                // idx wraps to 0 on the last byte of a 256-byte transfer.
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == LAST_IDX) ? IDLE : READ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            page_q   <= 8'd0;
            idx_q    <= 8'd0;
            data_q   <= 8'd0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            parity_q <= ~parity_q;
        end
    end

    // ------------------------------------------------------------------
    // Bus steering, decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        cpu_ready  = 1'b0;
        dma_active = 1'b1;
        bus_addr   = cpu_addr;
        bus_d_out  = cpu_d_out;
        bus_write  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cpu_ready  = 1'b1;
                dma_active = 1'b0;
                bus_write  = cpu_write;
            end
            HALT: begin
                // CPU is stalled but its in-flight write still reaches the bus.
                bus_write = cpu_write;
            end
            ALIGN: begin
                bus_write = 1'b0;
            end
            READ: begin
                // Source never leaves the page: idx only covers the low byte.
                bus_addr = {page_q, idx_q};
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_d_out = data_q;
                bus_write = 1'b1;
            end
            default: begin
                cpu_ready  = 1'b1;
                dma_active = 1'b0;
                bus_write  = cpu_write;
            end
        endcase
    end

    assign cpu_d_in = bus_d_in;

endmodule
